hlsm_lat_dotdiv: RTL and testbench

- Parametrised successor to the fixed-schedule 16-bit HLSM latency blocks.
- Computes k = (a*b + c*d) / e and l = f / g.
- Operands are latched on a single-cycle Start pulse. Done pulses exactly LATENCY cycles later.
- Adds configurable width, signed/unsigned mode, Busy status and defined divide-by-zero results. Sits under the HLS latency-test top level as the datapath/controller pair for one scheduled expression.

---
 rtl/hlsm_pkg.sv | 21 ++
 rtl/hlsm_div_guard.sv | 36 +++
 rtl/hlsm_lat_dotdiv.sv | 154 +++++++++++++++
 tb/tb_hlsm_lat_dotdiv.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hlsm_pkg.sv
// Shared controller types and limits for the hlsm_lat_dotdiv latency block.
package hlsm_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      ADD  = 3'd2,
      DIV  = 3'd3,
      WAIT = 3'd4,
      FIN  = 3'd5
   } state_e;

   localparam int MIN_LATENCY = 4;
   localparam int MAX_LATENCY = 255;

   // Counter must be able to hold LATENCY itself.
   function automatic int cnt_width(input int latency);
      return $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/hlsm_div_guard.sv
// Combinational divide with a zero-divisor guard; quotient is 0 when den_i==0.
module hlsm_div_guard
   import hlsm_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SIGNED_MODE = 1
) (
   input  logic [WIDTH-1:0] num_i,
   input  logic [WIDTH-1:0] den_i,
   output logic [WIDTH-1:0] quot_o,
   output logic             zero_o
);

   logic signed [WIDTH-1:0] num_s;
   logic signed [WIDTH-1:0] den_s;
   logic                    ovf;

   assign num_s  = num_i;
   assign den_s  = den_i;
   assign zero_o = (den_i == '0);
   // MIN / -1 is not representable; wrap it back to MIN explicitly.
   assign ovf    = (num_i == {1'b1, {(WIDTH-1){1'b0}}}) && (den_i == '1);

   always_comb begin
      quot_o = '0;
      if (!zero_o) begin
         if (SIGNED_MODE != 0) begin
            if (ovf) quot_o = num_i;
            else     quot_o = num_s / den_s;
         end else begin
            quot_o = num_i / den_i;
         end
      end
   end

endmodule

// File: rtl/hlsm_lat_dotdiv.sv
// Fixed-latency k=(a*b+c*d)/e, l=f/g with Start/Busy/Done handshake.
// Optional macro HLSM_DIVZERO_FLAG_EN adds a DivZero flag qualified by Done.
module hlsm_lat_dotdiv
   import hlsm_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int LATENCY     = 11,
   parameter int SIGNED_MODE = 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] l,
   output logic             Busy,
`ifdef HLSM_DIVZERO_FLAG_EN
   output logic             DivZero,
`endif
   output logic             Done
);

   localparam int CW = cnt_width(LATENCY);

   if (LATENCY < MIN_LATENCY || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("hlsm_lat_dotdiv: LATENCY must be within 4..255");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, b_q, c_q, d_q, e_q, f_q, g_q;
   logic [WIDTH-1:0] a_d, b_d, c_d, d_d, e_d, f_d, g_d;
   logic [WIDTH-1:0] h_q, i_q, j_q, k_q, l_q;
   logic [WIDTH-1:0] h_d, i_d, j_d, k_d, l_d;
   logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
   logic [WIDTH-1:0] quot_k, quot_l;
   logic             zero_k, zero_l;
   logic             last_cnt;

   hlsm_div_guard #(.WIDTH(WIDTH), .SIGNED_MODE(SIGNED_MODE)) u_div_k (
      .num_i (j_q),
      .den_i (e_q),
      .quot_o(quot_k),
      .zero_o(zero_k)
   );

   hlsm_div_guard #(.WIDTH(WIDTH), .SIGNED_MODE(SIGNED_MODE)) u_div_l (
      .num_i (f_q),
      .den_i (g_q),
      .quot_o(quot_l),
      .zero_o(zero_l)
   );

   // cnt holds the number of edges since acceptance; FIN lands on the LATENCY-th busy cycle.
   assign last_cnt = (cnt_q == CW'(LATENCY - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
      e_d = e_q; f_d = f_q; g_d = g_q;
      h_d = h_q; i_d = i_q; j_d = j_q; k_d = k_q; l_d = l_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               a_d = a; b_d = b; c_d = c; d_d = d;
               e_d = e; f_d = f; g_d = g;
               k_d     = '0;
               l_d     = '0;
               busy_d  = 1'b1;
               cnt_d   = CW'(1);
               state_d = MUL;
            end
         end
         MUL: begin
            h_d     = a_q * b_q;
            i_d     = c_q * d_q;
            l_d     = quot_l;
            cnt_d   = cnt_q + CW'(1);
            state_d = ADD;
         end
         ADD: begin
            j_d     = h_q + i_q;
            cnt_d   = cnt_q + CW'(1);
            state_d = DIV;
         end
         DIV, WAIT: begin
            if (state_q == DIV) k_d = quot_k;
            cnt_d = cnt_q + CW'(1);
            if (last_cnt) begin
               state_d = FIN;
               done_d  = 1'b1;
               dz_d    = zero_k | zero_l;
            end else begin
               state_d = WAIT;
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
         e_q <= '0; f_q <= '0; g_q <= '0;
         h_q <= '0; i_q <= '0; j_q <= '0; k_q <= '0; l_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
         e_q <= e_d; f_q <= f_d; g_q <= g_d;
         h_q <= h_d; i_q <= i_d; j_q <= j_d; k_q <= k_d; l_q <= l_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign k    = k_q;
   assign l    = l_q;
   assign Busy = busy_q;
   assign Done = done_q;

`ifdef HLSM_DIVZERO_FLAG_EN
   assign DivZero = dz_q;
`else
   logic unused_divzero;
   assign unused_divzero = dz_q;
`endif

endmodule

// File: tb/tb_hlsm_lat_dotdiv.sv
// Bench for hlsm_lat_dotdiv: signed L=11, unsigned L=11 and signed L=4 instances share stimulus.
module tb_hlsm_lat_dotdiv;

   typedef struct packed {
      logic [15:0] a, b, c, d, e, f, g;
   } ops_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0, g = '0;
   logic [15:0] k_s, l_s, k_u, l_u, k_4, l_4;
   logic        busy_s, done_s, busy_u, done_u, busy_4, done_4;
`ifdef HLSM_DIVZERO_FLAG_EN
   logic        dz_s, dz_u, dz_4;
`endif

   int   tests = 0;
   int   failed = 0;
   ops_t ops_at [0:40];

   always #5 clk = ~clk;

   hlsm_lat_dotdiv #(.WIDTH(16), .LATENCY(11), .SIGNED_MODE(1)) dut_s (
      .Clk(clk), .Rst(rst), .Start(start),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .k(k_s), .l(l_s), .Busy(busy_s),
`ifdef HLSM_DIVZERO_FLAG_EN
      .DivZero(dz_s),
`endif
      .Done(done_s));

   hlsm_lat_dotdiv #(.WIDTH(16), .LATENCY(11), .SIGNED_MODE(0)) dut_u (
      .Clk(clk), .Rst(rst), .Start(start),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .k(k_u), .l(l_u), .Busy(busy_u),
`ifdef HLSM_DIVZERO_FLAG_EN
      .DivZero(dz_u),
`endif
      .Done(done_u));

   hlsm_lat_dotdiv #(.WIDTH(16), .LATENCY(4), .SIGNED_MODE(1)) dut_4 (
      .Clk(clk), .Rst(rst), .Start(start),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
      .k(k_4), .l(l_4), .Busy(busy_4),
`ifdef HLSM_DIVZERO_FLAG_EN
      .DivZero(dz_4),
`endif
      .Done(done_4));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, truncating division, 0 on divide by zero.
   function automatic logic [15:0] mdiv(input logic [15:0] n, input logic [15:0] dd, input bit sgn);
      int ni, di, q;
      if (dd == 16'h0) return 16'h0;
      if (sgn) begin
         ni = int'($signed(n));
         di = int'($signed(dd));
      end else begin
         ni = int'(n);
         di = int'(dd);
      end
      q = ni / di;
      return q[15:0];
   endfunction

   function automatic logic [15:0] mk(input ops_t o, input bit sgn);
      int unsigned s;
      s = o.a * o.b + o.c * o.d;
      return mdiv(s[15:0], o.e, sgn);
   endfunction

   function automatic logic [15:0] ml(input ops_t o, input bit sgn);
      return mdiv(o.f, o.g, sgn);
   endfunction

   function automatic bit has_zero(input ops_t o);
      return (o.e == 16'h0) || (o.g == 16'h0);
   endfunction

   function automatic ops_t rnd_ops();
      ops_t o;
      o.a = 16'($urandom); o.b = 16'($urandom); o.c = 16'($urandom); o.d = 16'($urandom);
      o.e = 16'($urandom); o.f = 16'($urandom); o.g = 16'($urandom);
      if ($urandom_range(0, 7) == 0) o.e = 16'h0;
      if ($urandom_range(0, 7) == 0) o.g = 16'h0;
      if ($urandom_range(0, 3) == 0) o.e = 16'($urandom_range(1, 9));
      return o;
   endfunction

   task automatic apply(input ops_t o);
      a = o.a; b = o.b; c = o.c; d = o.d; e = o.e; f = o.f; g = o.g;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".k_s"}, k_s, 16'h0);       chk({tag, ".l_s"}, l_s, 16'h0);
      chk({tag, ".k_u"}, k_u, 16'h0);       chk({tag, ".l_u"}, l_u, 16'h0);
      chk({tag, ".k_4"}, k_4, 16'h0);       chk({tag, ".l_4"}, l_4, 16'h0);
      chk({tag, ".busy_s"}, busy_s, 16'h0); chk({tag, ".done_s"}, done_s, 16'h0);
      chk({tag, ".busy_u"}, busy_u, 16'h0); chk({tag, ".done_u"}, done_u, 16'h0);
      chk({tag, ".busy_4"}, busy_4, 16'h0); chk({tag, ".done_4"}, done_4, 16'h0);
   endtask

   // One request accepted by all three instances; inputs are scrambled right after acceptance.
   task automatic run_txn(input ops_t o, input string tag);
      apply(o);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      apply(rnd_ops());
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (cyc > 1) begin @(posedge clk); #1; end
         chk({tag, ".busy_s"}, busy_s, 16'(cyc <= 11));
         chk({tag, ".done_s"}, done_s, 16'(cyc == 11));
         chk({tag, ".busy_u"}, busy_u, 16'(cyc <= 11));
         chk({tag, ".done_u"}, done_u, 16'(cyc == 11));
         chk({tag, ".busy_4"}, busy_4, 16'(cyc <= 4));
         chk({tag, ".done_4"}, done_4, 16'(cyc == 4));
         chk({tag, ".k_s"}, k_s, (cyc >= 4) ? mk(o, 1'b1) : 16'h0);
         chk({tag, ".l_s"}, l_s, (cyc >= 2) ? ml(o, 1'b1) : 16'h0);
         chk({tag, ".k_u"}, k_u, (cyc >= 4) ? mk(o, 1'b0) : 16'h0);
         chk({tag, ".l_u"}, l_u, (cyc >= 2) ? ml(o, 1'b0) : 16'h0);
         chk({tag, ".k_4"}, k_4, (cyc >= 4) ? mk(o, 1'b1) : 16'h0);
         chk({tag, ".l_4"}, l_4, (cyc >= 2) ? ml(o, 1'b1) : 16'h0);
`ifdef HLSM_DIVZERO_FLAG_EN
         chk({tag, ".dz_s"}, dz_s, 16'((cyc == 11) && has_zero(o)));
         chk({tag, ".dz_u"}, dz_u, 16'((cyc == 11) && has_zero(o)));
         chk({tag, ".dz_4"}, dz_4, 16'((cyc == 4) && has_zero(o)));
`endif
      end
   endtask

   initial begin
      ops_t o;

      #3;
      chk_all_zero("reset");
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      chk_all_zero("idle_after_reset");

      o = '{a:16'd3, b:16'd4, c:16'd5, d:16'd6, e:16'd7, f:16'd100, g:16'd9};
      run_txn(o, "basic");
      o = '{a:-16'sd3, b:16'd4, c:16'd2, d:16'd1, e:16'd3, f:-16'sd7, g:16'd2};
      run_txn(o, "signed");
      o = '{a:16'd11, b:16'd13, c:16'd17, d:16'd19, e:16'd0, f:16'd55, g:16'd0};
      run_txn(o, "divzero");
      o = '{a:16'h8000, b:16'd1, c:16'd0, d:16'd0, e:16'hFFFF, f:16'h8000, g:16'hFFFF};
      run_txn(o, "minneg1");
      for (int n = 0; n < 6; n++) run_txn(rnd_ops(), $sformatf("rand%0d", n));

      // Start held high: accepts every LATENCY+1 cycles, operands change every cycle.
      o = rnd_ops();
      apply(o);
      ops_at[0] = o;
      start = 1'b1;
      for (int cyc = 1; cyc <= 36; cyc++) begin
         @(posedge clk); #1;
         chk("hold.busy_s", busy_s, 16'((cyc % 12) != 0));
         chk("hold.done_s", done_s, 16'((cyc % 12) == 11));
         chk("hold.done_u", done_u, 16'((cyc % 12) == 11));
         chk("hold.busy_4", busy_4, 16'((cyc % 5) != 0));
         chk("hold.done_4", done_4, 16'((cyc % 5) == 4));
         if ((cyc % 12) == 11) begin
            chk("hold.k_s", k_s, mk(ops_at[cyc-11], 1'b1));
            chk("hold.l_s", l_s, ml(ops_at[cyc-11], 1'b1));
            chk("hold.k_u", k_u, mk(ops_at[cyc-11], 1'b0));
            chk("hold.l_u", l_u, ml(ops_at[cyc-11], 1'b0));
`ifdef HLSM_DIVZERO_FLAG_EN
            chk("hold.dz_s", dz_s, 16'(has_zero(ops_at[cyc-11])));
`endif
         end
         if ((cyc % 5) == 4) begin
            chk("hold.k_4", k_4, mk(ops_at[cyc-4], 1'b1));
            chk("hold.l_4", l_4, ml(ops_at[cyc-4], 1'b1));
         end
         o = rnd_ops();
         apply(o);
         ops_at[cyc] = o;
      end
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a run discards it.
      o = '{a:16'd3, b:16'd4, c:16'd5, d:16'd6, e:16'd7, f:16'd100, g:16'd9};
      apply(o);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("midreset");
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(posedge clk); #1;
         chk("post_reset.done_s", done_s, 16'h0);
         chk("post_reset.busy_s", busy_s, 16'h0);
         chk("post_reset.done_4", done_4, 16'h0);
      end
      run_txn(o, "after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
